// File: rtl/lif_pkg.sv
// Shared types, default widths and arithmetic helpers for the LIF neuron fabric.
// The router and synapse blocks import the same default constants.
package lif_pkg;

    typedef enum logic {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } lif_state_e;

    localparam int unsigned LIF_WIDTH = 8;
    localparam int unsigned LIF_TAU_W = 3;
    localparam int unsigned LIF_REF_W = 4;
    localparam int unsigned LIF_CNT_W = 8;

    // Unsigned add clamped to 2^width-1; operands are zero-extended to 32 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] s;
        logic [32:0] max;
        s   = {1'b0, a} + {1'b0, b};
        max = (33'd1 << width) - 33'd1;
        return (s > max) ? max[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_core_if.sv
// Per-neuron bus: step enable, synaptic current and config in; spike and state out.
interface lif_neuron_core_if
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH = LIF_WIDTH,
    parameter int unsigned TAU_W = LIF_TAU_W,
    parameter int unsigned REF_W = LIF_REF_W,
    parameter int unsigned CNT_W = LIF_CNT_W
);
    logic             en;
    logic [WIDTH-1:0] isyn;
    logic [WIDTH-1:0] threshold;
    logic [TAU_W-1:0] leak_shift;
    logic [REF_W-1:0] ref_cycles;
    logic             spike;
    logic             refractory;
    logic [WIDTH-1:0] membrane;
    logic [CNT_W-1:0] spike_count;

    modport master (
        output en, isyn, threshold, leak_shift, ref_cycles,
        input  spike, refractory, membrane, spike_count
    );

    modport slave (
        input  en, isyn, threshold, leak_shift, ref_cycles,
        output spike, refractory, membrane, spike_count
    );
endinterface

// File: rtl/lif_refrac_timer.sv
// Loadable refractory down-counter; done flags the last refractory edge.
module lif_refrac_timer
    import lif_pkg::*;
#(
    parameter int unsigned REF_W = LIF_REF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [REF_W-1:0] load_val,
    output logic             done
);
    logic [REF_W-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (load) begin
            timer <= load_val;
        end else if (en && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign done = (timer == REF_W'(1));
endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron with saturating membrane, refractory period
// and saturating spike counter.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH = LIF_WIDTH,
    parameter int unsigned TAU_W = LIF_TAU_W,
    parameter int unsigned REF_W = LIF_REF_W,
    parameter int unsigned CNT_W = LIF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    lif_neuron_core_if.slave  bus
);
    lif_state_e       state;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] leak;
    logic [WIDTH-1:0] base;
    logic [31:0]      sum;
    logic             fire;
    logic             spike_q;
    logic [CNT_W-1:0] cnt;
    logic             t_load;
    logic             t_en;
    logic             t_done;

    always_comb begin
        leak = v >> bus.leak_shift;
        base = v - leak;
        sum  = sat_add(32'(base), 32'(bus.isyn), WIDTH);
        fire = (bus.threshold != '0) && (sum >= 32'(bus.threshold));
    end

    assign t_load = bus.en && (state == INTEG) && fire && (bus.ref_cycles != '0);
    assign t_en   = bus.en && (state == REFRAC);

    lif_refrac_timer #(.REF_W(REF_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (t_en),
        .load     (t_load),
        .load_val (bus.ref_cycles),
        .done     (t_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v       <= '0;
            state   <= INTEG;
            spike_q <= 1'b0;
            cnt     <= '0;
        end else if (!bus.en) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= 1'b0;
            case (state)
                INTEG: begin
                    if (fire) begin
                        spike_q <= 1'b1;
                        v       <= '0;
                        if (cnt != '1) cnt <= cnt + 1'b1;
                        if (bus.ref_cycles != '0) state <= REFRAC;
                    end else begin
                        v <= sum[WIDTH-1:0];
                    end
                end
                REFRAC: begin
                    v <= '0;
                    if (t_done) state <= INTEG;
                end
                default: state <= INTEG;
            endcase
        end
    end

    assign bus.spike       = spike_q;
    assign bus.refractory  = (state == REFRAC);
    assign bus.membrane    = v;
    assign bus.spike_count = cnt;
endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core: vector table plus multi-cycle corner sequences.
module tb_lif_neuron_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    lif_neuron_core_if #(.WIDTH(8), .TAU_W(3), .REF_W(4), .CNT_W(8)) bus ();

    lif_neuron_core #(.WIDTH(8), .TAU_W(3), .REF_W(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       en;
        bit [7:0] isyn;
        bit [7:0] th;
        bit [2:0] ls;
        bit [3:0] rc;
        bit       e_spike;
        bit       e_ref;
        bit [7:0] e_mem;
        bit [7:0] e_cnt;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(bit rst, bit en, int isyn, int th, int ls, int rc,
                                bit sp, bit rf, int mem, int cnt);
        vec_t r;
        r.rst = rst; r.en = en; r.isyn = 8'(isyn); r.th = 8'(th);
        r.ls = 3'(ls); r.rc = 4'(rc);
        r.e_spike = sp; r.e_ref = rf; r.e_mem = 8'(mem); r.e_cnt = 8'(cnt);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit en, input int isyn, input int th, input int ls, input int rc);
        bus.en = en; bus.isyn = 8'(isyn); bus.threshold = 8'(th);
        bus.leak_shift = 3'(ls); bus.ref_cycles = 4'(rc);
    endtask

    task automatic do_reset();
        bus.en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int first_spike;
        int exp_cnt;

        // constant drive: th=4, ls=2, rc=3, isyn=2 -> period 5
        vecs[0]  = mk(1,1,2,4,2,3, 0,0,2,0);
        vecs[1]  = mk(0,1,2,4,2,3, 1,1,0,1);
        vecs[2]  = mk(0,1,2,4,2,3, 0,1,0,1);
        vecs[3]  = mk(0,1,2,4,2,3, 0,1,0,1);
        vecs[4]  = mk(0,1,2,4,2,3, 0,0,0,1);
        vecs[5]  = mk(0,1,2,4,2,3, 0,0,2,1);
        vecs[6]  = mk(0,1,2,4,2,3, 1,1,0,2);
        vecs[7]  = mk(0,1,2,4,2,3, 0,1,0,2);
        vecs[8]  = mk(0,1,2,4,2,3, 0,1,0,2);
        vecs[9]  = mk(0,1,2,4,2,3, 0,0,0,2);
        vecs[10] = mk(0,1,2,4,2,3, 0,0,2,2);
        vecs[11] = mk(0,1,2,4,2,3, 1,1,0,3);
        // leak decay with floor at 1
        vecs[12] = mk(1,1,100,200,1,3, 0,0,100,0);
        vecs[13] = mk(0,1,0,200,1,3, 0,0,50,0);
        vecs[14] = mk(0,1,0,200,1,3, 0,0,25,0);
        vecs[15] = mk(0,1,0,200,1,3, 0,0,13,0);
        vecs[16] = mk(0,1,0,200,1,3, 0,0,7,0);
        vecs[17] = mk(0,1,0,200,1,3, 0,0,4,0);
        vecs[18] = mk(0,1,0,200,1,3, 0,0,2,0);
        vecs[19] = mk(0,1,0,200,1,3, 0,0,1,0);
        vecs[20] = mk(0,1,0,200,1,3, 0,0,1,0);
        vecs[21] = mk(0,1,0,200,1,3, 0,0,1,0);
        // saturation with firing disabled
        vecs[22] = mk(1,1,255,0,7,3, 0,0,255,0);
        vecs[23] = mk(0,1,255,0,7,3, 0,0,255,0);
        vecs[24] = mk(0,1,255,0,7,3, 0,0,255,0);
        vecs[25] = mk(0,1,255,0,7,3, 0,0,255,0);

        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        check("reset_spike", 32'(bus.spike), 0);
        check("reset_ref",   32'(bus.refractory), 0);
        check("reset_mem",   32'(bus.membrane), 0);
        check("reset_cnt",   32'(bus.spike_count), 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            drive(vecs[i].en, vecs[i].isyn, vecs[i].th, vecs[i].ls, vecs[i].rc);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_spike", i), 32'(bus.spike),       32'(vecs[i].e_spike));
            check($sformatf("vec%0d_ref", i),   32'(bus.refractory),  32'(vecs[i].e_ref));
            check($sformatf("vec%0d_mem", i),   32'(bus.membrane),    32'(vecs[i].e_mem));
            check($sformatf("vec%0d_cnt", i),   32'(bus.spike_count), 32'(vecs[i].e_cnt));
        end

        // enable gap of 4 cycles inside refractory delays the second spike 7 -> 11
        do_reset();
        first_spike = 0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            drive(!(e >= 4 && e <= 7), 2, 4, 2, 3);
            @(posedge clk);
            #1;
            if (e >= 4 && e <= 7) begin
                check($sformatf("gap%0d_ref", e),   32'(bus.refractory), 1);
                check($sformatf("gap%0d_spike", e), 32'(bus.spike), 0);
                check($sformatf("gap%0d_cnt", e),   32'(bus.spike_count), 1);
            end
            if (e > 2 && bus.spike && first_spike == 0) first_spike = e;
            if (e == 11) check("gap_cnt_after", 32'(bus.spike_count), 2);
        end
        check("gap_spike_edge", 32'(first_spike), 11);

        // ref_cycles=0: fire every edge, counter saturates at 255
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            drive(1, 1, 1, 0, 0);
            @(posedge clk);
            #1;
            exp_cnt = (k > 255) ? 255 : k;
            check($sformatf("r0_%0d_spike", k), 32'(bus.spike), 1);
            check($sformatf("r0_%0d_ref", k),   32'(bus.refractory), 0);
            check($sformatf("r0_%0d_cnt", k),   32'(bus.spike_count), 32'(exp_cnt));
        end

        // async reset right after the fire edge, no clock edge involved
        do_reset();
        for (int e = 1; e <= 2; e++) begin
            @(negedge clk);
            drive(1, 2, 4, 2, 3);
            @(posedge clk);
        end
        #1;
        check("ar_pre_spike", 32'(bus.spike), 1);
        check("ar_pre_ref",   32'(bus.refractory), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_spike", 32'(bus.spike), 0);
        check("ar_ref",   32'(bus.refractory), 0);
        check("ar_mem",   32'(bus.membrane), 0);
        check("ar_cnt",   32'(bus.spike_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_post1_mem", 32'(bus.membrane), 2);
        check("ar_post1_ref", 32'(bus.refractory), 0);
        @(posedge clk);
        #1;
        check("ar_post2_spike", 32'(bus.spike), 1);
        check("ar_post2_cnt",   32'(bus.spike_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lif_neuron_core.md
Name: lif_neuron_core

Overview:
Parametrised leaky integrate-and-fire neuron, the next generation of our single-neuron LIF block.
- Adds runtime-configurable threshold, leak shift and refractory length.
- Adds saturating membrane arithmetic, a clock enable, a proper refractory state machine and a spike counter.
- Instanced per neuron inside the spiking-network fabric; driven by the synapse/current-summing stage, its spike output feeds the event router.

Parameters:
WIDTH, 8, membrane/current/threshold width in bits
TAU_W, 3, width of leak_shift input
REF_W, 4, width of refractory-length input and internal timer
CNT_W, 8, width of saturating spike counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
en  input  1  time-step enable; when low all state held
isyn  input  WIDTH  synaptic current for this step, unsigned
threshold  input  WIDTH  firing threshold, unsigned; 0 disables firing
leak_shift  input  TAU_W  leak = v >> leak_shift
ref_cycles  input  REF_W  refractory length in enabled cycles
spike  output  1  one-cycle registered spike pulse
refractory  output  1  high while in REFRAC state
membrane  output  WIDTH  current membrane value v (registered)
spike_count  output  CNT_W  saturating count of spikes since reset

Behaviour:
- Reset (async, rst_n=0): v=0, state=INTEG, timer=0, spike=0, refractory=0, spike_count=0. Reset mid-refractory or mid-integration aborts immediately; first post-reset edge behaves as from power-up.
- en=0: v, state, timer, spike_count held; spike forced 0 on that edge.
- States: INTEG, REFRAC. refractory = (state==REFRAC).
- INTEG, en=1:
  - sum = v - (v >> leak_shift) + isyn, computed in WIDTH+1 bits.
  - sum saturates to 2^WIDTH-1.
  - leak_shift=0 gives sum = isyn (full leak).
- Fire condition: threshold != 0 and sum >= threshold, evaluated on the post-leak, post-input sum in the same edge.
- Fire edge:
  - spike<=1 for exactly one cycle; v<=0; spike_count increments, saturating at 2^CNT_W-1.
  - If ref_cycles != 0: state<=REFRAC, timer<=ref_cycles.
  - If ref_cycles == 0: stay INTEG; next edge may fire again.
- No fire: v<=sum, spike<=0.
- REFRAC, en=1:
  - isyn ignored; v held 0; spike 0.
  - If timer==1: state<=INTEG. Otherwise timer<=timer-1.
  - Refractory therefore lasts exactly ref_cycles enabled edges.
- Config sampling:
  - threshold, leak_shift and isyn are sampled every enabled INTEG edge.
  - ref_cycles is sampled only on the fire edge; changing it mid-REFRAC does not alter the running countdown.
- Leak floor: when v < 2^leak_shift the leak term is 0, so v is held, not decayed to 0. This is intentional.
- Latency: isyn to membrane is 1 edge. Crossing edge to spike high is the same edge (spike registered alongside the v reset).
- Spike period under constant drive: integrate edges to threshold + ref_cycles.

Decomposition:
- Package lif_pkg:
  - state enum (INTEG, REFRAC).
  - Saturating-add function sat_add(a, b, width).
  - Default parameter constants shared with the router and synapse blocks.
- One sub-module: lif_refrac_timer. Loadable down-counter with load, en and done (timer==1) outputs. Owns timer and the REFRAC exit.
- Integrate/leak/compare stays inline in lif_neuron_core.

Test Plan:
- Constant drive, WIDTH=8, threshold=4, leak_shift=2, ref_cycles=3, isyn=2, en=1 -> v=2 at edge1; spike at edge2 (v->0); refractory high edges 3-5; v=2 at edge6; spike at edge7; period 5 sustained; spike_count=2 after edge7.
- Leak decay, threshold=200, leak_shift=1, one edge isyn=100 then isyn=0 -> membrane 100,50,25,13,7,4,2,1,1,1 (floor holds at 1); no spike.
- Saturation, threshold=0, isyn=255, leak_shift=7 -> membrane 255 at every edge, never wraps, spike never asserts.
- Enable gating, as the first scenario but en=0 for 4 cycles during REFRAC -> timer and refractory frozen; spike is delayed by exactly 4 cycles; spike_count unchanged during gap.
- ref_cycles=0, threshold=1, isyn=1 -> spike every enabled edge; refractory never high; spike_count saturates at 255 after 255 spikes and stays.
- Async reset mid-REFRAC (rst_n low between edges) -> spike, refractory, membrane and spike_count go 0 immediately without a clock; after release, integration restarts from v=0 in INTEG.
